dram_slot_arb: RTL and testbench
================================

DRAM_SLOT_ARB -- requirements
Module: dram_slot_arb

Interface
REQ-001 SHALL have parameter STARVE_MAX, default 4, meaning the number of consecutive CPU slots after which a pending DMA request wins.
REQ-002 SHALL have port clk, input, 1 bit: system clock; all logic runs on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have ports c0, c1, c2, c3, inputs, 1 bit each: one-hot phase strobes; a DRAM slot spans c0..c3.
REQ-005 SHALL have port vid_req, input, 1 bit: video fetch request for the next slot.
REQ-006 SHALL have port vid_addr, input, 21 bits: video word address.
REQ-007 SHALL have port cpu_req, input, 1 bit: CPU access request.
REQ-008 SHALL have port cpu_addr, input, 21 bits: CPU word address.
REQ-009 SHALL have port cpu_rnw, input, 1 bit: 1 = read, 0 = write.
REQ-010 SHALL have port cpu_wrbsel, input, 1 bit: byte select for CPU writes.
REQ-011 SHALL have port cpu_wrdata, input, 8 bits: CPU write byte.
REQ-012 SHALL have port dma_req, input, 1 bit: DMA request.
REQ-013 SHALL have port dma_addr, input, 21 bits: DMA word address.
REQ-014 SHALL have port dma_rnw, input, 1 bit: DMA direction, 1 = read.
REQ-015 SHALL have port dma_wrdata, input, 16 bits: DMA write word.
REQ-016 SHALL have port cpu_next, output, 1 bit: next slot is available to the CPU.
REQ-017 SHALL have port cpu_strobe, output, 1 bit: CPU read data valid on dram_rddata.
REQ-018 SHALL have port cpu_latch, output, 1 bit: consumer selects dram_rddata over its cache.
REQ-019 SHALL have port dma_next, output, 1 bit: DMA granted; source advances.
REQ-020 SHALL have port dma_strobe, output, 1 bit: DMA read data valid.
REQ-021 SHALL have port vid_strobe, output, 1 bit: video data valid.
REQ-022 SHALL have port dram_req, output, 1 bit: slot is active.
REQ-023 SHALL have port dram_rnw, output, 1 bit: slot direction.
REQ-024 SHALL have port dram_addr, output, 21 bits: slot word address.
REQ-025 SHALL have port dram_bsel, output, 2 bits: byte enables.
REQ-026 SHALL have port dram_wrdata, output, 16 bits: slot write word.

Function
REQ-027 Arbitration SHALL occur only at c3; the winner owns the following c0..c3 slot.
REQ-028 Priority SHALL be video > forced DMA > CPU > DMA > IDLE.
REQ-029 Forced DMA SHALL be asserted when dma_req is high and the starvation count equals STARVE_MAX.
REQ-030 The starvation count SHALL increment on each CPU grant while dma_req is high, saturating at STARVE_MAX.
REQ-031 The starvation count SHALL clear on any DMA grant, and whenever dma_req is low at c3.
REQ-032 cpu_next SHALL be combinational: !vid_req && !forced DMA; it SHALL be independent of cpu_req.
REQ-033 A CPU grant SHALL occur at c3 when cpu_req && cpu_next.
REQ-034 Request fields SHALL be registered at c3 and held constant for the whole slot.
REQ-035 CPU write: dram_bsel SHALL be {cpu_wrbsel, !cpu_wrbsel}, and dram_wrdata SHALL be {cpu_wrdata, cpu_wrdata}.
REQ-036 Video and DMA slots SHALL use dram_bsel = 2'b11; a video slot SHALL always be a read.
REQ-037 Read data SHALL be valid at c2 of the slot (read latency fixed at 2 clk after c0).
REQ-038 cpu_strobe, dma_strobe and vid_strobe SHALL be one-clk pulses at c2 of a read slot owned by that requester.
REQ-039 cpu_latch SHALL be high during c2 and c3 of a CPU read slot, and low otherwise.
REQ-040 Write slots SHALL produce no strobe.
REQ-041 dma_next SHALL be a one-clk pulse at the c3 where DMA is granted.
REQ-042 dram_req SHALL be high for c0..c3 of a non-IDLE slot.
REQ-043 Phase strobes SHALL be assumed exactly one-hot; the block is not required to check them.
REQ-044 Simultaneous vid_req, cpu_req and dma_req SHALL resolve per REQ-028 in the same c3.
REQ-045 A requester dropping its request mid-slot SHALL NOT abort the slot.

Reset
REQ-046 During rst: owner = IDLE, starvation count = 0, and all outputs SHALL be 0 except cpu_next.
REQ-047 During rst, cpu_next SHALL follow REQ-032.
REQ-048 An rst asserted mid-slot SHALL abandon the slot; no strobe SHALL issue for it.
REQ-049 The first grant after reset SHALL occur at the first c3 after rst deasserts.

Structure
REQ-050 A shared package SHALL hold the owner enumeration (IDLE, VID, CPU, DMA) and the 21-bit address width constant.
REQ-051 The priority/starvation decision SHALL be one sub-module, dram_slot_pick (combinational select plus the starvation counter); slot registers and strobes SHALL stay in the top.

Verification
REQ-052 vid_req = 1 and cpu_req = 1 at c3 -> cpu_next = 0, a video slot, vid_strobe at the next c2, no cpu_strobe.
REQ-053 CPU read, cpu_addr = 0x012345 -> dram_addr = 0x012345 and dram_rnw = 1 for c0..c3; cpu_strobe at c2; cpu_latch at c2 and c3.
REQ-054 CPU write, cpu_wrbsel = 1, cpu_wrdata = 0xA5 -> dram_bsel = 2'b10, dram_wrdata = 0xA5A5, no strobe.
REQ-055 cpu_req and dma_req held high, STARVE_MAX = 4 -> grants CPU, CPU, CPU, CPU, DMA (dma_next pulse), then CPU.
REQ-056 rst asserted at c1 of a CPU read slot -> no cpu_strobe, dram_req = 0; after release, first grant at the next c3.
REQ-057 No requests -> dram_req stays 0 and the starvation count stays 0 over 100 slots.

Source files
------------

// File: rtl/dram_slot_arb_pkg.sv
// Shared types for the DRAM slot arbiter: slot owner encoding and address width.
package dram_slot_arb_pkg;
  localparam int unsigned ADDR_W = 21;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    VID  = 2'd1,
    CPU  = 2'd2,
    DMA  = 2'd3
  } owner_t;
endpackage

// File: rtl/dram_slot_arb_if.sv
// Requester/DRAM bundle for the slot arbiter; master = requesters + phase source, slave = arbiter.
interface dram_slot_arb_if;
  import dram_slot_arb_pkg::*;

  logic              c0, c1, c2, c3;
  logic              vid_req;
  logic [ADDR_W-1:0] vid_addr;
  logic              cpu_req;
  logic [ADDR_W-1:0] cpu_addr;
  logic              cpu_rnw;
  logic              cpu_wrbsel;
  logic [7:0]        cpu_wrdata;
  logic              dma_req;
  logic [ADDR_W-1:0] dma_addr;
  logic              dma_rnw;
  logic [15:0]       dma_wrdata;
  logic              cpu_next;
  logic              cpu_strobe;
  logic              cpu_latch;
  logic              dma_next;
  logic              dma_strobe;
  logic              vid_strobe;
  logic              dram_req;
  logic              dram_rnw;
  logic [ADDR_W-1:0] dram_addr;
  logic [1:0]        dram_bsel;
  logic [15:0]       dram_wrdata;

  modport master (
    output c0, c1, c2, c3,
    output vid_req, vid_addr,
    output cpu_req, cpu_addr, cpu_rnw, cpu_wrbsel, cpu_wrdata,
    output dma_req, dma_addr, dma_rnw, dma_wrdata,
    input  cpu_next, cpu_strobe, cpu_latch, dma_next, dma_strobe, vid_strobe,
    input  dram_req, dram_rnw, dram_addr, dram_bsel, dram_wrdata
  );

  modport slave (
    input  c0, c1, c2, c3,
    input  vid_req, vid_addr,
    input  cpu_req, cpu_addr, cpu_rnw, cpu_wrbsel, cpu_wrdata,
    input  dma_req, dma_addr, dma_rnw, dma_wrdata,
    output cpu_next, cpu_strobe, cpu_latch, dma_next, dma_strobe, vid_strobe,
    output dram_req, dram_rnw, dram_addr, dram_bsel, dram_wrdata
  );
endinterface

// File: rtl/dram_slot_pick.sv
// Slot winner selection (video > forced DMA > CPU > DMA) and the DMA starvation counter.
module dram_slot_pick
  import dram_slot_arb_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   c3,
  input  logic   vid_req,
  input  logic   cpu_req,
  input  logic   dma_req,
  output owner_t win,
  output logic   cpu_next
);
  localparam int unsigned CW = $clog2(STARVE_MAX + 2);

  logic [CW-1:0] starve_cnt;
  logic          forced;

  always_comb forced   = dma_req && (starve_cnt == CW'(STARVE_MAX));
  always_comb cpu_next = !vid_req && !forced;

  always_comb begin
    win = IDLE;
    if (vid_req)                win = VID;
    else if (forced)            win = DMA;
    else if (cpu_req)           win = CPU;
    else if (dma_req)           win = DMA;
  end

  // Count only CPU wins taken while DMA was waiting; any DMA win or idle DMA resets it.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (c3) begin
      if (!dma_req || win == DMA)
        starve_cnt <= '0;
      else if (win == CPU && starve_cnt != CW'(STARVE_MAX))
        starve_cnt <= starve_cnt + 1'b1;
    end
  end
endmodule

// File: rtl/dram_slot_arb.sv
// DRAM slot arbiter: picks a slot owner at c3, holds the slot fields for c0..c3, issues read strobes at c2.
module dram_slot_arb
  import dram_slot_arb_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input logic            clk,
  input logic            rst,
  dram_slot_arb_if.slave bus
);
  owner_t            win;
  owner_t            owner;
  logic              pick_cpu_next;
  logic [ADDR_W-1:0] addr;
  logic              rnw;
  logic [1:0]        bsel;
  logic [15:0]       wrdata;
  logic              rd_issue;
  logic              cpu_strobe_r, dma_strobe_r, vid_strobe_r, cpu_latch_r;

  dram_slot_pick #(.STARVE_MAX(STARVE_MAX)) u_pick (
    .clk      (clk),
    .rst      (rst),
    .c3       (bus.c3),
    .vid_req  (bus.vid_req),
    .cpu_req  (bus.cpu_req),
    .dma_req  (bus.dma_req),
    .win      (win),
    .cpu_next (pick_cpu_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      owner        <= IDLE;
      addr         <= '0;
      rnw          <= 1'b0;
      bsel         <= '0;
      wrdata       <= '0;
      rd_issue     <= 1'b0;
      cpu_strobe_r <= 1'b0;
      dma_strobe_r <= 1'b0;
      vid_strobe_r <= 1'b0;
      cpu_latch_r  <= 1'b0;
    end else begin
      if (bus.c3) begin
        owner <= win;
        unique case (win)
          VID: begin
            addr   <= bus.vid_addr;
            rnw    <= 1'b1;
            bsel   <= 2'b11;
            wrdata <= '0;
          end
          CPU: begin
            addr   <= bus.cpu_addr;
            rnw    <= bus.cpu_rnw;
            bsel   <= bus.cpu_rnw ? 2'b11 : {bus.cpu_wrbsel, !bus.cpu_wrbsel};
            wrdata <= {bus.cpu_wrdata, bus.cpu_wrdata};
          end
          DMA: begin
            addr   <= bus.dma_addr;
            rnw    <= bus.dma_rnw;
            bsel   <= 2'b11;
            wrdata <= bus.dma_wrdata;
          end
          default: begin
            addr   <= '0;
            rnw    <= 1'b0;
            bsel   <= '0;
            wrdata <= '0;
          end
        endcase
      end
      // Read issued at c0 returns two clocks later, so strobes are loaded at the c1 edge.
      rd_issue     <= bus.c0 && rnw && (owner != IDLE);
      vid_strobe_r <= bus.c1 && rd_issue && (owner == VID);
      cpu_strobe_r <= bus.c1 && rd_issue && (owner == CPU);
      dma_strobe_r <= bus.c1 && rd_issue && (owner == DMA);
      cpu_latch_r  <= (bus.c1 && rd_issue && (owner == CPU)) || (cpu_latch_r && bus.c2);
    end
  end

  assign bus.cpu_next    = pick_cpu_next;
  assign bus.dma_next    = bus.c3 && (win == DMA) && !rst;
  assign bus.cpu_strobe  = cpu_strobe_r;
  assign bus.dma_strobe  = dma_strobe_r;
  assign bus.vid_strobe  = vid_strobe_r;
  assign bus.cpu_latch   = cpu_latch_r;
  assign bus.dram_req    = (owner != IDLE);
  assign bus.dram_rnw    = rnw;
  assign bus.dram_addr   = addr;
  assign bus.dram_bsel   = bsel;
  assign bus.dram_wrdata = wrdata;
endmodule

// File: tb/tb_dram_slot_arb.sv
// Scoreboard bench for dram_slot_arb: decisions push expected slots, a negedge monitor checks each slot.
module tb_dram_slot_arb;
  import dram_slot_arb_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  dram_slot_arb_if bus ();

  dram_slot_arb #(.STARVE_MAX(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic        active;
    logic        rnw;
    logic [20:0] addr;
    logic [1:0]  bsel;
    logic        chk_bsel;
    logic [15:0] wrdata;
    logic        chk_wr;
    logic [3:0]  vid_s, cpu_s, dma_s, latch;
    logic        dnext, cnext;
  } exp_t;

  exp_t q[$];
  int compared   = 0;
  int mismatched = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic exp_t e_idle(input string tag, input logic cn);
    exp_t e;
    e.tag = tag; e.active = 0; e.rnw = 0; e.addr = '0; e.bsel = '0; e.chk_bsel = 0;
    e.wrdata = '0; e.chk_wr = 0; e.vid_s = 0; e.cpu_s = 0; e.dma_s = 0; e.latch = 0;
    e.dnext = 0; e.cnext = cn;
    return e;
  endfunction

  function automatic exp_t e_vid(input string tag, input logic [20:0] a);
    exp_t e = e_idle(tag, 1'b0);
    e.active = 1; e.rnw = 1; e.addr = a; e.bsel = 2'b11; e.chk_bsel = 1; e.vid_s = 4'b0100;
    return e;
  endfunction

  function automatic exp_t e_cpu_rd(input string tag, input logic [20:0] a);
    exp_t e = e_idle(tag, 1'b1);
    e.active = 1; e.rnw = 1; e.addr = a; e.cpu_s = 4'b0100; e.latch = 4'b1100;
    return e;
  endfunction

  function automatic exp_t e_cpu_wr(input string tag, input logic [20:0] a,
                                    input logic [1:0] bs, input logic [15:0] wd);
    exp_t e = e_idle(tag, 1'b1);
    e.active = 1; e.rnw = 0; e.addr = a; e.bsel = bs; e.chk_bsel = 1; e.wrdata = wd; e.chk_wr = 1;
    return e;
  endfunction

  function automatic exp_t e_dma(input string tag, input logic [20:0] a, input logic r,
                                 input logic [15:0] wd, input logic cn);
    exp_t e = e_idle(tag, cn);
    e.active = 1; e.rnw = r; e.addr = a; e.bsel = 2'b11; e.chk_bsel = 1; e.dnext = 1;
    e.wrdata = wd; e.chk_wr = !r; e.dma_s = r ? 4'b0100 : 4'b0000;
    return e;
  endfunction

  // Phase source: one-hot c0..c3 advancing 1 time unit after every rising edge.
  int ph = 0;
  initial begin
    bus.c0 = 1; bus.c1 = 0; bus.c2 = 0; bus.c3 = 0;
    forever begin
      @(posedge clk); #1;
      ph = (ph + 1) % 4;
      bus.c0 = (ph == 0); bus.c1 = (ph == 1); bus.c2 = (ph == 2); bus.c3 = (ph == 3);
    end
  end

  // Monitor: a window opens at a deciding c3 and closes at the next c3 of the owned slot.
  logic        mon_en = 0, win_open = 0, o_stable, o_dn, o_cn, o_rnw;
  logic [3:0]  o_req, o_vid, o_cpu, o_dma, o_lat;
  logic [20:0] o_addr;
  logic [1:0]  o_bsel;
  logic [15:0] o_wd;

  always @(negedge clk) begin
    if (!mon_en) begin
      win_open = 0;
    end else begin
      if (win_open) begin
        int p;
        p = bus.c0 ? 0 : bus.c1 ? 1 : bus.c2 ? 2 : 3;
        o_req[p] = bus.dram_req; o_vid[p] = bus.vid_strobe; o_cpu[p] = bus.cpu_strobe;
        o_dma[p] = bus.dma_strobe; o_lat[p] = bus.cpu_latch;
        if (p == 0) begin
          o_addr = bus.dram_addr; o_rnw = bus.dram_rnw; o_bsel = bus.dram_bsel; o_wd = bus.dram_wrdata;
        end else if (o_addr !== bus.dram_addr || o_rnw !== bus.dram_rnw ||
                     o_bsel !== bus.dram_bsel || o_wd !== bus.dram_wrdata) begin
          o_stable = 0;
        end
      end
      if (bus.c3) begin
        if (win_open) begin
          exp_t e;
          e = (q.size() > 0) ? q.pop_front() : e_idle("unsched", 1'b1);
          chk({e.tag, ".dram_req"}, o_req, e.active ? 4'hF : 4'h0);
          if (e.active) begin
            chk({e.tag, ".rnw"}, o_rnw, e.rnw);
            chk({e.tag, ".addr"}, o_addr, e.addr);
            chk({e.tag, ".held"}, o_stable, 1);
            if (e.chk_bsel) chk({e.tag, ".bsel"}, o_bsel, e.bsel);
            if (e.chk_wr)   chk({e.tag, ".wrdata"}, o_wd, e.wrdata);
          end
          chk({e.tag, ".vid_strobe"}, o_vid, e.vid_s);
          chk({e.tag, ".cpu_strobe"}, o_cpu, e.cpu_s);
          chk({e.tag, ".dma_strobe"}, o_dma, e.dma_s);
          chk({e.tag, ".cpu_latch"}, o_lat, e.latch);
          chk({e.tag, ".dma_next"}, o_dn, e.dnext);
          chk({e.tag, ".cpu_next"}, o_cn, e.cnext);
        end
        o_dn = bus.dma_next; o_cn = bus.cpu_next; o_stable = 1;
        o_req = 0; o_vid = 0; o_cpu = 0; o_dma = 0; o_lat = 0;
        win_open = 1;
      end
    end
  end

  task automatic clr_reqs();
    bus.vid_req = 0; bus.cpu_req = 0; bus.dma_req = 0;
  endtask

  task automatic wait_c3();
    while (!bus.c3) begin @(posedge clk); #2; end
  endtask

  // Present current inputs at the next c3, then drop requests right after the deciding edge.
  task automatic decide(input exp_t e, input logic push);
    wait_c3();
    if (push) q.push_back(e);
    @(posedge clk); #2;
    clr_reqs();
  endtask

  task automatic cpu_in(input logic [20:0] a, input logic r, input logic bs, input logic [7:0] d);
    bus.cpu_req = 1; bus.cpu_addr = a; bus.cpu_rnw = r; bus.cpu_wrbsel = bs; bus.cpu_wrdata = d;
  endtask

  task automatic dma_in(input logic [20:0] a, input logic r, input logic [15:0] d);
    bus.dma_req = 1; bus.dma_addr = a; bus.dma_rnw = r; bus.dma_wrdata = d;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 16) begin @(posedge clk); #2; n++; end
    chk("drain", q.size(), 0);
  endtask

  initial begin
    clr_reqs();
    bus.vid_addr = '0; bus.cpu_addr = '0; bus.cpu_rnw = 1; bus.cpu_wrbsel = 0; bus.cpu_wrdata = '0;
    bus.dma_addr = '0; bus.dma_rnw = 1; bus.dma_wrdata = '0;

    rst = 1;
    repeat (6) @(posedge clk);
    #2;
    chk("rst.dram_req", bus.dram_req, 0);
    chk("rst.strobes", {bus.cpu_strobe, bus.dma_strobe, bus.vid_strobe, bus.cpu_latch}, 0);
    chk("rst.dram_fields", {bus.dram_rnw, bus.dram_addr, bus.dram_bsel, bus.dram_wrdata}, 0);
    chk("rst.cpu_next", bus.cpu_next, 1);
    bus.vid_req = 1; #1;
    chk("rst.cpu_next_vid", bus.cpu_next, 0);
    bus.vid_req = 0;
    wait_c3();
    bus.dma_req = 1; bus.cpu_req = 1; #1;
    chk("rst.dma_next", bus.dma_next, 0);
    @(posedge clk); #2;
    chk("rst.no_grant", bus.dram_req, 0);
    clr_reqs();
    while (!bus.c0) begin @(posedge clk); #2; end
    rst = 0;
    mon_en = 1;

    bus.vid_req = 1; bus.vid_addr = 21'h1ABCDE; cpu_in(21'h000111, 1, 0, 8'h00);
    decide(e_vid("vid_over_cpu", 21'h1ABCDE), 1);
    cpu_in(21'h012345, 1, 0, 8'h00);
    decide(e_cpu_rd("cpu_rd", 21'h012345), 1);
    cpu_in(21'h000777, 0, 1, 8'hA5);
    decide(e_cpu_wr("cpu_wr_hi", 21'h000777, 2'b10, 16'hA5A5), 1);
    cpu_in(21'h1FFFFF, 0, 0, 8'h3C);
    decide(e_cpu_wr("cpu_wr_lo", 21'h1FFFFF, 2'b01, 16'h3C3C), 1);
    dma_in(21'h00F0F0, 1, 16'h0000);
    decide(e_dma("dma_rd", 21'h00F0F0, 1, 16'h0000, 1), 1);
    dma_in(21'h100001, 0, 16'hBEEF);
    decide(e_dma("dma_wr", 21'h100001, 0, 16'hBEEF, 1), 1);
    decide(e_idle("idle", 1), 1);
    bus.vid_req = 1; bus.vid_addr = 21'h000042; cpu_in(21'h000043, 1, 0, 0); dma_in(21'h000044, 1, 0);
    decide(e_vid("all_three", 21'h000042), 1);

    for (int i = 0; i < 4; i++) begin
      cpu_in(21'h000100 + 21'(i), 1, 0, 0); dma_in(21'h000200, 1, 0);
      decide(e_cpu_rd("starve_cpu", 21'h000100 + 21'(i)), 1);
    end
    cpu_in(21'h000104, 1, 0, 0); dma_in(21'h000200, 1, 0);
    decide(e_dma("starve_dma", 21'h000200, 1, 0, 0), 1);
    cpu_in(21'h000105, 1, 0, 0); dma_in(21'h000201, 1, 0);
    decide(e_cpu_rd("after_forced", 21'h000105), 1);
    decide(e_idle("dma_drop", 1), 1);

    for (int i = 0; i < 3; i++) begin
      cpu_in(21'h000300, 1, 0, 0); dma_in(21'h000400, 1, 0);
      decide(e_cpu_rd("pre_clear", 21'h000300), 1);
    end
    cpu_in(21'h000301, 1, 0, 0);
    decide(e_cpu_rd("clear_cpu", 21'h000301), 1);
    for (int i = 0; i < 4; i++) begin
      cpu_in(21'h000310, 1, 0, 0); dma_in(21'h000400, 1, 0);
      decide(e_cpu_rd("post_clear", 21'h000310), 1);
    end
    bus.vid_req = 1; bus.vid_addr = 21'h000500; cpu_in(21'h000310, 1, 0, 0); dma_in(21'h000400, 1, 0);
    decide(e_vid("vid_over_forced", 21'h000500), 1);
    cpu_in(21'h000310, 1, 0, 0); dma_in(21'h000401, 0, 16'h1234);
    decide(e_dma("forced_wr", 21'h000401, 0, 16'h1234, 0), 1);
    drain();

    mon_en = 0;
    cpu_in(21'h0AAAAA, 1, 0, 0);
    decide(e_idle("unused", 1), 0);
    @(posedge clk); #2;
    rst = 1;
    @(posedge clk); #2;
    chk("midrst.c2_strobe", bus.cpu_strobe, 0);
    chk("midrst.c2_req", bus.dram_req, 0);
    chk("midrst.c2_latch", bus.cpu_latch, 0);
    @(posedge clk); #2;
    chk("midrst.c3_req_latch", {bus.dram_req, bus.cpu_latch}, 0);
    @(posedge clk); #2;
    rst = 0;
    mon_en = 1;
    cpu_in(21'h0ABCDE, 1, 0, 0);
    decide(e_cpu_rd("first_after_rst", 21'h0ABCDE), 1);

    for (int i = 0; i < 100; i++) decide(e_idle("idle100", 1), 1);
    drain();
    chk("idle100.starve_cnt", 32'(dut.u_pick.starve_cnt), 0);
    mon_en = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
